// File: rtl/gol_engine.sv
// gol_engine: Game of Life board store, row edit port, run/stop/single-step control and population statistics.
// Latency: btn_step sampled at edge N -> board updated after edge N+ROWS+1 (one row per clock, then commit).
// Backpressure: none; single-cycle button pulses, edits honoured only in EDIT, busy marks CALC/COMMIT.
module gol_engine #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 25000000
) (
  input  logic                     ClkPort,
  input  logic                     reset,
  input  logic                     btn_run,
  input  logic                     btn_step,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [COLS-1:0]          wr_data,
  input  logic                     wrap_mode,
  input  logic                     auto_stop,
  output logic [ROWS*COLS-1:0]     board,
  output logic [2:0]               state,
  output logic                     busy,
  output logic [CNT_W-1:0]         generation_cnt,
  output logic [CNT_W-1:0]         birth_cnt,
  output logic [CNT_W-1:0]         death_cnt,
  output logic                     stable,
  output logic                     extinct
);

  localparam int RW  = $clog2(ROWS);
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW  = $clog2(COLS + 1);
  localparam int PW  = $clog2(ROWS * COLS + 1);
  localparam int SW  = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_INI    = 3'd0,
    S_EDIT   = 3'd1,
    S_RUN    = 3'd2,
    S_CALC   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      run_q, run_d;
  logic [PSW-1:0]            psc_q, psc_d;
  logic [RW-1:0]             row_q, row_d;
  logic                      wrap_q, wrap_d;
  logic [ROWS-1:0][COLS-1:0] board_q, shadow_q;
  logic [PW-1:0]             pend_b_q, pend_d_q;
  logic [CNT_W-1:0]          gen_q, birth_q, death_q;
  logic                      stable_q;

  logic                      tick, last_row, new_stable, new_extinct, enter_calc, wr_ok;
  logic [COLS-1:0]           row_prev, row_cur, row_next, row_new, row_births, row_deaths;
  logic [COLS+1:0]           ext_prev, ext_cur, ext_next;
  logic [3:0]                nbr;
  logic [CW-1:0]             nb_row, nd_row;
  logic [SW-1:0]             gen_sum, birth_sum, death_sum;
  logic [CNT_W-1:0]          gen_sat, birth_sat, death_sat;

  assign tick        = (psc_q == PSW'(TICK_DIV - 1));
  assign last_row    = (row_q == RW'(ROWS - 1));
  assign new_stable  = (shadow_q == board_q);
  assign new_extinct = (shadow_q == '0);
  assign wr_ok       = (32'(wr_row) < 32'(ROWS));

  // State register plus the registered busy flag that tracks it.
  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      state_q <= S_INI;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state selection: btn_run has priority over btn_step and over the rate tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INI:    state_d = S_EDIT;
      S_EDIT: begin
        if (btn_run)       state_d = S_RUN;
        else if (btn_step) state_d = S_CALC;
      end
      S_RUN: begin
        if (btn_run)       state_d = S_EDIT;
        else if (tick)     state_d = S_CALC;
      end
      S_CALC: begin
        if (last_row)      state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (run_q && !btn_run && !(auto_stop && (new_stable || new_extinct)))
          state_d = S_RUN;
        else
          state_d = S_EDIT;
      end
      default:             state_d = S_INI;
    endcase
  end

  // FSM outputs: busy follows the upcoming state so it is registered alongside it.
  always_comb begin
    busy_d     = (state_d == S_CALC) || (state_d == S_COMMIT);
    enter_calc = (state_d == S_CALC) && (state_q != S_CALC);
  end

  // Run flag, prescaler, row index and latched edge mode next-state values.
  always_comb begin
    run_d = run_q;
    case (state_q)
      S_INI:    run_d = 1'b0;
      S_EDIT:   if (btn_run) run_d = 1'b1;
      S_RUN:    if (btn_run) run_d = 1'b0;
      S_CALC:   if (btn_run) run_d = 1'b0;
      S_COMMIT: if (state_d != S_RUN) run_d = 1'b0;
      default:  run_d = 1'b0;
    endcase
    psc_d  = (state_q == S_RUN && !tick && !btn_run) ? psc_q + PSW'(1) : '0;
    row_d  = (state_q == S_CALC && !last_row) ? row_q + RW'(1) : '0;
    wrap_d = enter_calc ? wrap_mode : wrap_q;
  end

  // Control registers.
  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      run_q  <= 1'b0;
      psc_q  <= '0;
      row_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      psc_q  <= psc_d;
      row_q  <= row_d;
      wrap_q <= wrap_d;
    end
  end

  // Fetch the rows above, at and below the row being computed; missing rows read dead unless wrapping.
  always_comb begin
    row_cur  = board_q[row_q];
    row_prev = '0;
    row_next = '0;
    if (row_q != '0)   row_prev = board_q[row_q - RW'(1)];
    else if (wrap_q)   row_prev = board_q[ROWS-1];
    if (!last_row)     row_next = board_q[row_q + RW'(1)];
    else if (wrap_q)   row_next = board_q[0];
  end

  // B3/S23 for one row: pad each row with its wrapped (or dead) edge columns, then count neighbours.
  always_comb begin
    ext_prev = {wrap_q & row_prev[0], row_prev, wrap_q & row_prev[COLS-1]};
    ext_cur  = {wrap_q & row_cur[0],  row_cur,  wrap_q & row_cur[COLS-1]};
    ext_next = {wrap_q & row_next[0], row_next, wrap_q & row_next[COLS-1]};
    row_new  = '0;
    nbr      = '0;
    for (int c = 0; c < COLS; c++) begin
      nbr = 4'(ext_prev[c]) + 4'(ext_prev[c+1]) + 4'(ext_prev[c+2])
          + 4'(ext_cur[c])                      + 4'(ext_cur[c+2])
          + 4'(ext_next[c]) + 4'(ext_next[c+1]) + 4'(ext_next[c+2]);
      row_new[c] = (nbr == 4'd3) || (row_cur[c] && (nbr == 4'd2));
    end
    row_births = row_new & ~row_cur;
    row_deaths = row_cur & ~row_new;
    nb_row     = '0;
    nd_row     = '0;
    for (int c = 0; c < COLS; c++) begin
      nb_row = nb_row + CW'(row_births[c]);
      nd_row = nd_row + CW'(row_deaths[c]);
    end
  end

  // Edits land only in EDIT (clear wins); CALC fills the shadow, COMMIT swaps it in whole.
  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      board_q  <= '0;
      shadow_q <= '0;
    end else begin
      case (state_q)
        S_INI:    board_q <= '0;
        S_EDIT: begin
          if (clear)               board_q <= '0;
          else if (wr_en && wr_ok) board_q[wr_row] <= wr_data;
        end
        S_CALC:   shadow_q[row_q] <= row_new;
        S_COMMIT: board_q <= shadow_q;
        default:  ;
      endcase
    end
  end

  // Counter sums are formed one bit wider than either operand, then clamped to the counter range.
  always_comb begin
    gen_sum   = SW'(gen_q) + SW'(1);
    birth_sum = SW'(birth_q) + SW'(pend_b_q);
    death_sum = SW'(death_q) + SW'(pend_d_q);
    gen_sat   = (gen_sum   > SW'(CNT_MAX)) ? CNT_MAX : gen_sum[CNT_W-1:0];
    birth_sat = (birth_sum > SW'(CNT_MAX)) ? CNT_MAX : birth_sum[CNT_W-1:0];
    death_sat = (death_sum > SW'(CNT_MAX)) ? CNT_MAX : death_sum[CNT_W-1:0];
  end

  // Pending per-generation totals restart at row 0; statistics update only on commit.
  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      pend_b_q <= '0;
      pend_d_q <= '0;
      gen_q    <= '0;
      birth_q  <= '0;
      death_q  <= '0;
      stable_q <= 1'b0;
    end else begin
      case (state_q)
        S_INI: begin
          gen_q    <= '0;
          birth_q  <= '0;
          death_q  <= '0;
          stable_q <= 1'b0;
        end
        S_CALC: begin
          pend_b_q <= ((row_q == '0) ? '0 : pend_b_q) + PW'(nb_row);
          pend_d_q <= ((row_q == '0) ? '0 : pend_d_q) + PW'(nd_row);
        end
        S_COMMIT: begin
          gen_q    <= gen_sat;
          birth_q  <= birth_sat;
          death_q  <= death_sat;
          stable_q <= new_stable;
        end
        default: ;
      endcase
    end
  end

  assign board          = board_q;
  assign state          = state_q;
  assign busy           = busy_q;
  assign generation_cnt = gen_q;
  assign birth_cnt      = birth_q;
  assign death_cnt      = death_q;
  assign stable         = stable_q;
  assign extinct        = (board_q == '0);

endmodule

// File: tb/tb_gol_engine.sv
// tb_gol_engine: drives gol_engine with directed and random boards and checks against a cell-level model.
// Expected boards come from neighbour sums over the toroidal or bounded grid, not from the row pipeline.
// Counters, stable and extinct are tracked per generation in the model with saturation.
module tb_gol_engine;

  localparam int ROWS     = 10;
  localparam int COLS     = 12;
  localparam int CNT_W    = 5;
  localparam int TICK_DIV = 4;
  localparam int RW       = $clog2(ROWS);
  localparam int MAXC     = (1 << CNT_W) - 1;
  localparam int GEN_T    = TICK_DIV + ROWS + 1;

  logic                 ClkPort, reset;
  logic                 btn_run, btn_step, clear, wr_en, wrap_mode, auto_stop;
  logic [RW-1:0]        wr_row;
  logic [COLS-1:0]      wr_data;
  logic [ROWS*COLS-1:0] board;
  logic [2:0]           state;
  logic                 busy, stable, extinct;
  logic [CNT_W-1:0]     generation_cnt, birth_cnt, death_cnt;

  gol_engine #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV)) dut (
    .ClkPort(ClkPort), .reset(reset), .btn_run(btn_run), .btn_step(btn_step),
    .clear(clear), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .wrap_mode(wrap_mode), .auto_stop(auto_stop), .board(board), .state(state),
    .busy(busy), .generation_cnt(generation_cnt), .birth_cnt(birth_cnt),
    .death_cnt(death_cnt), .stable(stable), .extinct(extinct)
  );

  initial ClkPort = 1'b0;
  always #5 ClkPort = ~ClkPort;

  int n_tests = 0;
  int n_fail  = 0;

  logic [COLS-1:0] mrow [ROWS];
  int  mgen, mbirth, mdeath;
  bit  mstable;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ClkPort);
    #1;
  endtask

  function automatic logic [127:0] mflat();
    logic [127:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = mrow[r];
    return f;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) mrow[r] = '0;
    mgen = 0; mbirth = 0; mdeath = 0; mstable = 0;
  endtask

  // One generation straight from the rules: sum the 8 neighbours of each cell.
  task automatic model_step();
    logic [COLS-1:0] nxt [ROWS];
    int n, rr, cc, nb, nd;
    bit alive;
    nb = 0; nd = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr; cc = c + dc;
            if (wrap_mode) n += int'(mrow[(rr + ROWS) % ROWS][(cc + COLS) % COLS]);
            else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) n += int'(mrow[rr][cc]);
          end
        end
        alive = mrow[r][c] ? (n == 2 || n == 3) : (n == 3);
        nxt[r][c] = alive;
        if (alive && !mrow[r][c]) nb++;
        if (!alive && mrow[r][c]) nd++;
      end
    end
    mstable = 1;
    for (int r = 0; r < ROWS; r++) if (nxt[r] != mrow[r]) mstable = 0;
    mrow   = nxt;
    mgen   = sat(mgen + 1);
    mbirth = sat(mbirth + nb);
    mdeath = sat(mdeath + nd);
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ":board"},   128'(board),          mflat());
    check_val({tag, ":gen"},     128'(generation_cnt), 128'(mgen));
    check_val({tag, ":births"},  128'(birth_cnt),      128'(mbirth));
    check_val({tag, ":deaths"},  128'(death_cnt),      128'(mdeath));
    check_val({tag, ":stable"},  128'(stable),         128'(mstable));
    check_val({tag, ":extinct"}, 128'(extinct),        128'(mflat() == '0));
    check_val({tag, ":state"},   128'(state),          128'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    for (int r = 0; r < ROWS; r++) mrow[r] = '0;
  endtask

  task automatic write_row(input int r, input logic [COLS-1:0] d);
    wr_en = 1'b1; wr_row = RW'(r); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (r < ROWS) mrow[r] = d;
  endtask

  // Single step: busy must last ROWS+1 samples and the board must not move until the commit.
  task automatic step_one(input string tag);
    logic [127:0] old;
    int nbusy;
    bit partial;
    old = mflat(); nbusy = 0; partial = 0;
    btn_step = 1'b1; tick(); btn_step = 1'b0;
    while (busy && nbusy < 200) begin
      nbusy++;
      if (128'(board) != old) partial = 1;
      tick();
    end
    check_val({tag, ":busy_len"}, 128'(nbusy), 128'(ROWS + 1));
    check_val({tag, ":no_partial"}, 128'(partial), 128'(0));
    model_step();
    check_all(tag);
  endtask

  // Start running and follow ngen commits, optionally checking the generation cadence.
  task automatic run_gens(input int ngen, input bit timing);
    int cyc, commits, last_rise;
    bit pb;
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    cyc = 0; commits = 0; last_rise = -1;
    while (commits < ngen && cyc < 3000) begin
      pb = busy; tick(); cyc++;
      if (busy && !pb) begin
        if (timing) begin
          if (last_rise < 0) check_val("first_gen_delay", 128'(cyc), 128'(TICK_DIV));
          else check_val("gen_period", 128'(cyc - last_rise), 128'(GEN_T));
        end
        last_rise = cyc;
      end
      if (!busy && pb) begin
        commits++;
        model_step();
        check_val("run_board", 128'(board), mflat());
      end
    end
    if (commits < ngen) check_val("run_timeout", 128'(commits), 128'(ngen));
  endtask

  // Press btn_run while a generation is in flight: it completes and the engine drops to EDIT.
  task automatic stop_run(input string tag);
    int cyc;
    cyc = 0;
    while (!busy && cyc < 100) begin tick(); cyc++; end
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin tick(); cyc++; end
    model_step();
    check_all(tag);
    repeat (GEN_T) tick();
    check_val({tag, ":stays_edit"}, 128'(state), 128'(1));
  endtask

  // Run with auto_stop until the engine leaves on its own after one generation.
  task automatic run_until_stop(input string tag);
    int cyc;
    bit pb, done;
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      pb = busy; tick(); cyc++;
      if (pb && !busy) done = 1;
    end
    check_val({tag, ":finished"}, 128'(done), 128'(1));
    model_step();
    check_all(tag);
    repeat (GEN_T) tick();
    check_val({tag, ":stays_edit"}, 128'(state), 128'(1));
  endtask

  logic [127:0] e;

  initial begin
    reset = 1'b1; btn_run = 0; btn_step = 0; clear = 0; wr_en = 0;
    wr_row = '0; wr_data = '0; wrap_mode = 0; auto_stop = 0;
    model_reset();
    #2;
    check_val("rst_state",   128'(state),          128'(0));
    check_val("rst_board",   128'(board),          128'(0));
    check_val("rst_busy",    128'(busy),           128'(0));
    check_val("rst_gen",     128'(generation_cnt), 128'(0));
    check_val("rst_stable",  128'(stable),         128'(0));
    check_val("rst_extinct", 128'(extinct),        128'(1));
    tick();
    reset = 1'b0;
    check_val("ini_state", 128'(state), 128'(0));
    tick();
    check_val("edit_state", 128'(state), 128'(1));

    // Blinker, bounded edges.
    write_row(5, 12'h070);
    step_one("blinker");
    e = '0;
    e[4*COLS +: COLS] = 12'h020; e[5*COLS +: COLS] = 12'h020; e[6*COLS +: COLS] = 12'h020;
    check_val("blinker_vertical", 128'(board), e);
    check_val("blinker_gen", 128'(generation_cnt), 128'(1));
    check_val("blinker_births", 128'(birth_cnt), 128'(2));
    check_val("blinker_deaths", 128'(death_cnt), 128'(2));
    check_val("blinker_stable", 128'(stable), 128'(0));

    // Glider in run mode: cadence, 4-generation translation, stop mid-generation.
    do_reset();
    write_row(0, 12'h002); write_row(1, 12'h004); write_row(2, 12'h007);
    run_gens(4, 1'b1);
    e = '0;
    e[1*COLS +: COLS] = 12'h004; e[2*COLS +: COLS] = 12'h008; e[3*COLS +: COLS] = 12'h00E;
    check_val("glider_shift", 128'(board), e);
    stop_run("glider_stop");

    // Corner glider: wraps to the top-left with wrap=1, freezes into a block with wrap=0.
    wrap_mode = 1'b1;
    do_clear();
    write_row(7, 12'h400); write_row(8, 12'h800); write_row(9, 12'hE00);
    for (int i = 0; i < 8; i++) step_one("wrap_glider");
    e = '0;
    e[9*COLS +: COLS] = 12'h001; e[0*COLS +: COLS] = 12'h002; e[1*COLS +: COLS] = 12'h803;
    check_val("wrap_glider_pos", 128'(board), e);
    wrap_mode = 1'b0;
    do_clear();
    write_row(7, 12'h400); write_row(8, 12'h800); write_row(9, 12'hE00);
    for (int i = 0; i < 8; i++) step_one("edge_glider");
    check_val("edge_glider_stable", 128'(stable), 128'(1));

    // Auto-stop on a still life and on extinction.
    auto_stop = 1'b1;
    do_reset();
    write_row(3, 12'h018); write_row(4, 12'h018);
    run_until_stop("block_auto");
    check_val("block_stable", 128'(stable), 128'(1));
    check_val("block_gen", 128'(generation_cnt), 128'(1));
    do_reset();
    write_row(2, 12'h010);
    run_until_stop("single_auto");
    check_val("single_deaths", 128'(death_cnt), 128'(1));
    check_val("single_extinct", 128'(extinct), 128'(1));
    auto_stop = 1'b0;

    // Counter saturation with a free-running blinker.
    do_reset();
    write_row(5, 12'h070);
    run_gens(35, 1'b0);
    stop_run("sat");
    check_val("sat_gen", 128'(generation_cnt), 128'(MAXC));
    check_val("sat_births", 128'(birth_cnt), 128'(MAXC));
    check_val("sat_deaths", 128'(death_cnt), 128'(MAXC));

    // Edit rules.
    do_reset();
    write_row(ROWS, 12'hFFF);
    check_val("wr_row_oob", 128'(board), 128'(0));
    write_row(3, 12'h0A5);
    wr_en = 1'b1; clear = 1'b1; wr_row = RW'(4); wr_data = 12'hFFF;
    tick();
    wr_en = 1'b0; clear = 1'b0;
    for (int r = 0; r < ROWS; r++) mrow[r] = '0;
    check_val("clear_beats_wr", 128'(board), 128'(0));
    write_row(2, 12'h3C0);
    btn_run = 1'b1; btn_step = 1'b1; tick(); btn_run = 1'b0; btn_step = 1'b0;
    check_val("run_beats_step", 128'(state), 128'(2));
    wr_en = 1'b1; wr_row = RW'(6); wr_data = 12'hFFF; tick(); wr_en = 1'b0;
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    check_all("wr_in_run");

    // Reset while a generation is being computed.
    btn_step = 1'b1; tick(); btn_step = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #2;
    model_reset();
    check_val("midcalc_board", 128'(board), 128'(0));
    check_val("midcalc_gen", 128'(generation_cnt), 128'(0));
    check_val("midcalc_state", 128'(state), 128'(0));
    tick();
    reset = 1'b0;
    tick();
    check_val("midcalc_edit", 128'(state), 128'(1));

    // Random boards and edge modes, stepped and compared against the model.
    for (int k = 0; k < 6; k++) begin
      do_clear();
      for (int r = 0; r < ROWS; r++) write_row(r, COLS'($urandom & $urandom));
      wrap_mode = 1'($urandom_range(0, 1));
      for (int s = 0; s < 3; s++) step_one("random");
    end

    // Random edit traffic, including out-of-range rows and clear/write collisions.
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 2))
        0: write_row($urandom_range(0, (1 << RW) - 1), COLS'($urandom));
        1: begin
          wr_en = 1'b1; clear = 1'b1; wr_row = RW'($urandom_range(0, ROWS - 1)); wr_data = COLS'($urandom);
          tick();
          wr_en = 1'b0; clear = 1'b0;
          for (int r = 0; r < ROWS; r++) mrow[r] = '0;
        end
        default: write_row($urandom_range(0, ROWS - 1), COLS'($urandom));
      endcase
      check_val("rand_edit", 128'(board), mflat());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gol_engine.md
Name: gol_engine

Overview:
- Parametrised Game of Life engine: board store, edit port, run/stop/single-step control and population statistics in one block.
- Generalises the fixed 16x16 INI/SET/ALG/STOP controller to ROWSxCOLS boards, toroidal or dead-border edges, a programmable generation rate and auto-stop.
- Next-generation computation is sequential, one row per clock, into a shadow buffer that is committed atomically.
- Sits between the debounced button/switch front-end and the display/statistics logic.

Parameters:
ROWS, 16, board height (>=3)
COLS, 16, board width (>=3)
CNT_W, 16, width of generation/birth/death counters
TICK_DIV, 25000000, clocks between generations while running (>=1)

Ports:
ClkPort  in  1  system clock
reset  in  1  asynchronous, active-high
btn_run  in  1  single-cycle pulse; toggles run/stop
btn_step  in  1  single-cycle pulse; compute exactly one generation
clear  in  1  single-cycle pulse; zero the board (EDIT only)
wr_en  in  1  row write strobe (EDIT only)
wr_row  in  clog2(ROWS)  row index for write
wr_data  in  COLS  row contents; bit c = column c
wrap_mode  in  1  1 = toroidal edges, 0 = outside cells dead
auto_stop  in  1  1 = leave RUN on stable or extinct board
board  out  ROWS*COLS  current board; bit r*COLS+c = row r, col c
state  out  3  encoded FSM state: INI=0, EDIT=1, RUN=2, CALC=3, COMMIT=4
busy  out  1  high in CALC and COMMIT
generation_cnt  out  CNT_W  generations committed since INI
birth_cnt  out  CNT_W  cumulative births
death_cnt  out  CNT_W  cumulative deaths
stable  out  1  last committed generation changed no cell
extinct  out  1  board is all zero

Behaviour:
- Reset (async): state=INI, board=0, all counters=0, stable=0, busy=0, run flag=0, prescaler=0. extinct follows board, so it is 1.
- INI: one cycle, then EDIT. Board and counters are held at 0.
- EDIT: applies clear (board<=0, counters untouched), else wr_en with wr_row<ROWS (board row <= wr_data).
  - wr_row>=ROWS is ignored.
  - clear beats wr_en when both are asserted.
  - btn_run: run flag<=1, prescaler<=0, go to RUN.
  - btn_step (without btn_run): go to CALC. btn_run beats btn_step.
- wr_en and clear are ignored in every state other than EDIT.
- RUN: prescaler counts up each cycle.
  - At TICK_DIV-1: prescaler<=0, go to CALC.
  - btn_run: run flag<=0, go to EDIT.
- CALC:
  - wrap_mode is latched on CALC entry.
  - Row index starts at 0; each clock computes row r of the next board into the shadow buffer using B3/S23.
  - The neighbour count uses rows r-1, r, r+1 (mod ROWS when wrapped, dead when out of range) and similarly for columns.
  - Per-row birth/death popcounts (0..COLS) are accumulated into pending totals.
  - After row ROWS-1, go to COMMIT.
- COMMIT (1 cycle):
  - board<=shadow; generation_cnt+=1; birth_cnt+=pending births; death_cnt+=pending deaths; stable<=(shadow==board).
  - Next state: RUN if run flag=1 and not (auto_stop and (stable or extinct of the new board)); else EDIT, with run flag<=0.
- btn_run during CALC/COMMIT clears the run flag; the generation still completes, then EDIT. btn_step there is ignored.
- Latency: btn_step sampled at edge N -> board updated after edge N+ROWS+1; busy high for ROWS+1 cycles.
- All counters saturate at 2^CNT_W-1 (no wrap). Sums are computed wide, then clamped.
- extinct is combinational (board==0).
- Other outputs are registered.
- board never shows a partial generation.
- Reset mid-CALC/COMMIT aborts: the shadow buffer is discarded and state returns to INI.

Test Plan:
- Default params, wrap=0: blinker at row 5 cols 4..6, btn_step -> after ROWS+1 cycles col 5 rows 4..6 set; generation_cnt=1, birth_cnt=2, death_cnt=2, stable=0, busy high exactly 17 cycles.
- TICK_DIV=4, glider at rows 0..2 / cols 0..2, btn_run, 4 generations -> pattern shifted +1 row, +1 col; generations start every 4+ROWS+1 cycles; btn_run -> EDIT after the current commit.
- Glider at the bottom-right corner, wrap=1 vs wrap=0 after 8 generations -> wrap=1: intact glider at the top-left; wrap=0: board becomes a 2x2 block and stable=1.
- 2x2 block, auto_stop=1, btn_run -> one generation, stable=1, state returns to EDIT, generation_cnt=1; single live cell -> death_cnt=1, extinct=1, EDIT.
- CNT_W=4, blinker running 20 generations -> generation_cnt=15, birth_cnt=15, death_cnt=15, all held (saturated).
- Edit rules: wr_en with wr_row=ROWS ignored; wr_en+clear same cycle -> board 0; wr_en in RUN ignored; reset asserted mid-CALC -> board 0, counters 0, state INI then EDIT.
